// File: rtl/bp_update_scheduler.sv
// Write scheduler for the branch predictor tables. It sweeps every entry to its initial value after reset,
// then arbitrates queued BTB fills from ID against queued BHT updates from EX over one shared index.
module bp_update_scheduler #(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_SIZE = 8,
    parameter int QDEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          id_upd_valid,
    input  logic [WORD_SIZE-1:0]          id_upd_pc,
    input  logic [WORD_SIZE-1:0]          id_upd_target,
    output logic                          id_upd_ready,
    input  logic                          ex_upd_valid,
    input  logic [WORD_SIZE-1:0]          ex_upd_pc,
    input  logic                          ex_upd_taken,
    output logic                          ex_upd_ready,
    output logic [BTB_IDX_SIZE-1:0]       tbl_idx,
    output logic                          tbl_we_tag,
    output logic [WORD_SIZE-BTB_IDX_SIZE-1:0] tbl_tag,
    output logic [WORD_SIZE-1:0]          tbl_target,
    output logic                          tbl_we_bht,
    output logic [1:0]                    tbl_bht_wdata,
    input  logic [1:0]                    bht_rd_data,
    output logic                          init_busy
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int PW    = AW + 1;
    localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;

    localparam logic [PW-1:0]           PTR_ONE  = PW'(1);
    localparam logic [BTB_IDX_SIZE-1:0] IDX_ONE  = BTB_IDX_SIZE'(1);
    localparam logic [BTB_IDX_SIZE-1:0] IDX_LAST = '1;
    localparam logic [1:0]              BHT_INIT = 2'b10;

    typedef enum logic {INIT, RUN} state_t;

    state_t state, state_next;

    logic [BTB_IDX_SIZE-1:0] sweep_cnt;
    logic [BTB_IDX_SIZE-1:0] idx_hold;
    logic                    rr, rr_next;

    logic [WORD_SIZE-1:0]    id_pc_mem  [QDEPTH];
    logic [WORD_SIZE-1:0]    id_tgt_mem [QDEPTH];
    logic [PW-1:0]           id_wr_ptr, id_rd_ptr;
    logic                    id_empty, id_full, id_push, id_pop;

    logic [BTB_IDX_SIZE-1:0] ex_idx_mem [QDEPTH];
    logic                    ex_tkn_mem [QDEPTH];
    logic [PW-1:0]           ex_wr_ptr, ex_rd_ptr;
    logic                    ex_empty, ex_full, ex_push, ex_pop;

    logic [WORD_SIZE-1:0]    id_head_pc, id_head_tgt;
    logic [BTB_IDX_SIZE-1:0] id_head_idx, ex_head_idx;
    logic                    ex_head_tkn;
    logic                    grant_id, grant_ex;

    // Only the index bits of an EX update matter; the upper PC bits are not stored.
    logic unused_ex_pc_hi;
    assign unused_ex_pc_hi = ^ex_upd_pc[WORD_SIZE-1:BTB_IDX_SIZE];

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    assign id_empty     = (id_wr_ptr == id_rd_ptr);
    assign id_full      = (id_wr_ptr[AW] != id_rd_ptr[AW]) &&
                          (id_wr_ptr[AW-1:0] == id_rd_ptr[AW-1:0]);
    assign ex_empty     = (ex_wr_ptr == ex_rd_ptr);
    assign ex_full      = (ex_wr_ptr[AW] != ex_rd_ptr[AW]) &&
                          (ex_wr_ptr[AW-1:0] == ex_rd_ptr[AW-1:0]);

    assign id_upd_ready = !id_full;
    assign ex_upd_ready = !ex_full;
    assign id_push      = id_upd_valid && id_upd_ready;
    assign ex_push      = ex_upd_valid && ex_upd_ready;
    assign id_pop       = grant_id;
    assign ex_pop       = grant_ex;
    assign init_busy    = (state == INIT);

    assign id_head_pc   = id_pc_mem[id_rd_ptr[AW-1:0]];
    assign id_head_tgt  = id_tgt_mem[id_rd_ptr[AW-1:0]];
    assign id_head_idx  = id_head_pc[BTB_IDX_SIZE-1:0];
    assign ex_head_idx  = ex_idx_mem[ex_rd_ptr[AW-1:0]];
    assign ex_head_tkn  = ex_tkn_mem[ex_rd_ptr[AW-1:0]];

    // Queue payload storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (id_push) begin
            id_pc_mem[id_wr_ptr[AW-1:0]]  <= id_upd_pc;
            id_tgt_mem[id_wr_ptr[AW-1:0]] <= id_upd_target;
        end
        if (ex_push) begin
            ex_idx_mem[ex_wr_ptr[AW-1:0]] <= ex_upd_pc[BTB_IDX_SIZE-1:0];
            ex_tkn_mem[ex_wr_ptr[AW-1:0]] <= ex_upd_taken;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_cnt <= '0;
            idx_hold  <= '0;
            rr        <= 1'b0;
            id_wr_ptr <= '0;
            id_rd_ptr <= '0;
            ex_wr_ptr <= '0;
            ex_rd_ptr <= '0;
        end else begin
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + IDX_ONE;
            end
            if (id_push) begin
                id_wr_ptr <= id_wr_ptr + PTR_ONE;
            end
            if (id_pop) begin
                id_rd_ptr <= id_rd_ptr + PTR_ONE;
            end
            if (ex_push) begin
                ex_wr_ptr <= ex_wr_ptr + PTR_ONE;
            end
            if (ex_pop) begin
                ex_rd_ptr <= ex_rd_ptr + PTR_ONE;
            end
            rr       <= rr_next;
            idx_hold <= tbl_idx;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && sweep_cnt == IDX_LAST) begin
            state_next = RUN;
        end
    end

    // Arbitration and table write drive; the tables capture these on the edge that pops the queue heads.
    always_comb begin
        grant_id      = 1'b0;
        grant_ex      = 1'b0;
        rr_next       = rr;
        tbl_idx       = idx_hold;
        tbl_we_tag    = 1'b0;
        tbl_we_bht    = 1'b0;
        tbl_tag       = '0;
        tbl_target    = '0;
        tbl_bht_wdata = 2'b00;

        if (state == INIT) begin
            tbl_idx       = sweep_cnt;
            tbl_we_tag    = 1'b1;
            tbl_we_bht    = 1'b1;
            tbl_bht_wdata = BHT_INIT;
        end else begin
            if (!id_empty && !ex_empty) begin
                if (id_head_idx == ex_head_idx) begin
                    grant_id = 1'b1;
                    grant_ex = 1'b1;
                end else if (!rr) begin
                    grant_ex = 1'b1;
                    rr_next  = 1'b1;
                end else begin
                    grant_id = 1'b1;
                    rr_next  = 1'b0;
                end
            end else begin
                grant_id = !id_empty;
                grant_ex = !ex_empty;
            end

            if (grant_id) begin
                tbl_idx    = id_head_idx;
                tbl_we_tag = 1'b1;
                tbl_tag    = id_head_pc[WORD_SIZE-1:BTB_IDX_SIZE];
                tbl_target = id_head_tgt;
            end
            if (grant_ex) begin
                tbl_idx       = ex_head_idx;
                tbl_we_bht    = 1'b1;
                tbl_bht_wdata = ex_head_tkn ? sat_inc(bht_rd_data) : sat_dec(bht_rd_data);
            end
        end
    end

    // Keeps TAG_W referenced as the documented tag width of tbl_tag.
    if (TAG_W < 1) begin : g_bad_width
        $error("WORD_SIZE must exceed BTB_IDX_SIZE");
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: stimulus pushes expected table writes into a queue,
// a negedge monitor pops and compares every write the scheduler presents in RUN.
module tb_bp_update_scheduler;

    localparam int WS = 16;
    localparam int IW = 4;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_upd_valid, ex_upd_valid, ex_upd_taken;
    logic [WS-1:0] id_upd_pc, id_upd_target, ex_upd_pc;
    logic          id_upd_ready, ex_upd_ready;
    logic [IW-1:0] tbl_idx;
    logic          tbl_we_tag, tbl_we_bht;
    logic [WS-IW-1:0] tbl_tag;
    logic [WS-1:0] tbl_target;
    logic [1:0]    tbl_bht_wdata;
    logic [1:0]    bht_rd_data;
    logic          init_busy;

    logic [1:0]    bht_mem [1<<IW];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          we_tag;
        logic          we_bht;
        logic [IW-1:0] idx;
        logic [WS-IW-1:0] tag;
        logic [WS-1:0] target;
        logic [1:0]    wdata;
    } wr_t;

    wr_t exp_q[$];

    bp_update_scheduler #(.WORD_SIZE(WS), .BTB_IDX_SIZE(IW), .QDEPTH(QD)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_upd_valid(id_upd_valid), .id_upd_pc(id_upd_pc), .id_upd_target(id_upd_target),
        .id_upd_ready(id_upd_ready),
        .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc), .ex_upd_taken(ex_upd_taken),
        .ex_upd_ready(ex_upd_ready),
        .tbl_idx(tbl_idx), .tbl_we_tag(tbl_we_tag), .tbl_tag(tbl_tag), .tbl_target(tbl_target),
        .tbl_we_bht(tbl_we_bht), .tbl_bht_wdata(tbl_bht_wdata), .bht_rd_data(bht_rd_data),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Table model: combinational BHT read, write captured on the rising edge.
    assign bht_rd_data = bht_mem[tbl_idx];
    always @(posedge clk) begin
        if (tbl_we_bht) bht_mem[tbl_idx] <= tbl_bht_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_id(input logic [WS-1:0] pc, input logic [WS-1:0] tgt);
        wr_t e;
        e.we_tag = 1'b1; e.we_bht = 1'b0; e.idx = pc[IW-1:0];
        e.tag = pc[WS-1:IW]; e.target = tgt; e.wdata = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic exp_ex(input logic [IW-1:0] idx, input logic [1:0] w);
        wr_t e;
        e.we_tag = 1'b0; e.we_bht = 1'b1; e.idx = idx;
        e.tag = '0; e.target = '0; e.wdata = w;
        exp_q.push_back(e);
    endtask

    task automatic exp_merge(input logic [WS-1:0] pc, input logic [WS-1:0] tgt, input logic [1:0] w);
        wr_t e;
        e.we_tag = 1'b1; e.we_bht = 1'b1; e.idx = pc[IW-1:0];
        e.tag = pc[WS-1:IW]; e.target = tgt; e.wdata = w;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; holds the request(s) for one clock edge.
    task automatic drive(input logic iv, input logic [WS-1:0] ipc, input logic [WS-1:0] itgt,
                         input logic ev, input logic [WS-1:0] epc, input logic etk);
        id_upd_valid = iv; id_upd_pc = ipc; id_upd_target = itgt;
        ex_upd_valid = ev; ex_upd_pc = epc; ex_upd_taken = etk;
        @(posedge clk); #1;
        id_upd_valid = 1'b0;
        ex_upd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && !init_busy && (tbl_we_tag || tbl_we_bht)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got idx=%0d we_tag=%0b we_bht=%0b, required no write",
                         tbl_idx, tbl_we_tag, tbl_we_bht);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_we_tag", 32'(tbl_we_tag), 32'(e.we_tag));
                check("wr_we_bht", 32'(tbl_we_bht), 32'(e.we_bht));
                check("wr_idx", 32'(tbl_idx), 32'(e.idx));
                if (e.we_tag) begin
                    check("wr_tag", 32'(tbl_tag), 32'(e.tag));
                    check("wr_target", 32'(tbl_target), 32'(e.target));
                end
                if (e.we_bht) check("wr_bht_wdata", 32'(tbl_bht_wdata), 32'(e.wdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        id_upd_valid = 1'b0; id_upd_pc = '0; id_upd_target = '0;
        ex_upd_valid = 1'b0; ex_upd_pc = '0; ex_upd_taken = 1'b0;
        #2;
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_id_ready", 32'(id_upd_ready), 32'd1);
        check("rst_ex_ready", 32'(ex_upd_ready), 32'd1);

        // Initialization sweep: 16 cycles, indices 0..15.
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < (1 << IW); i++) begin
            @(negedge clk);
            check("init_busy", 32'(init_busy), 32'd1);
            check("init_idx", 32'(tbl_idx), 32'(i));
            check("init_we", 32'({tbl_we_tag, tbl_we_bht}), 32'b11);
            check("init_wdata", 32'(tbl_bht_wdata), 32'd2);
            check("init_tag_tgt", 32'({tbl_tag, tbl_target}), 32'd0);
        end
        @(negedge clk);
        check("run_init_busy", 32'(init_busy), 32'd0);
        check("run_idle_we", 32'({tbl_we_tag, tbl_we_bht}), 32'b00);
        @(posedge clk); #1;

        // Saturating counter at idx 3, starting from the initial value 2.
        begin
            logic [1:0] w [8];
            w = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
            for (int i = 0; i < 8; i++) begin
                exp_ex(4'd3, w[i]);
                drive(1'b0, '0, '0, 1'b1, 16'h0013, (i < 4));
            end
        end
        idle(3);

        // Contention with rr=0: EX first, then ID.
        exp_ex(4'd1, 2'd3);
        exp_id(16'h0025, 16'h0040);
        drive(1'b1, 16'h0025, 16'h0040, 1'b1, 16'h0031, 1'b1);
        idle(4);

        // Contention with rr=1: ID first, then EX.
        exp_id(16'h0068, 16'h1234);
        exp_ex(4'd2, 2'd1);
        drive(1'b1, 16'h0068, 16'h1234, 1'b1, 16'h0052, 1'b0);
        idle(4);

        // Same index on both heads: one merged write.
        exp_merge(16'h0047, 16'h0100, 2'd3);
        drive(1'b1, 16'h0047, 16'h0100, 1'b1, 16'h0017, 1'b1);
        idle(4);
        check("merge_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two requests pending.
        drive(1'b1, 16'h0039, 16'h0200, 1'b1, 16'h0023, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_init_busy", 32'(init_busy), 32'd1);
        check("arst_id_ready", 32'(id_upd_ready), 32'd1);
        check("arst_ex_ready", 32'(ex_upd_ready), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("resweep_idx0", 32'(tbl_idx), 32'd0);
        check("resweep_busy", 32'(init_busy), 32'd1);
        @(posedge clk); #1;

        // Fill the ID queue during INIT; the fifth request must be refused.
        for (int k = 1; k <= 4; k++) begin
            logic [WS-1:0] pc;
            logic [WS-1:0] tgt;
            pc  = 16'(k * 16'h0101);
            tgt = 16'(k * 16'h1111);
            exp_id(pc, tgt);
            drive(1'b1, pc, tgt, 1'b0, '0, 1'b0);
        end
        check("full_id_ready", 32'(id_upd_ready), 32'd0);
        drive(1'b1, 16'h0505, 16'h5555, 1'b0, '0, 1'b0);
        check("full_id_ready_hold", 32'(id_upd_ready), 32'd0);

        begin
            int budget;
            budget = 0;
            while (init_busy && budget < 40) begin
                @(negedge clk);
                budget++;
            end
        end
        check("init2_done", 32'(init_busy), 32'd0);
        check("first_run_ready", 32'(id_upd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_pop", 32'(id_upd_ready), 32'd1);
        idle(6);
        check("all_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
